fft_output_reorder: RTL

Buffers the 8-lane parallel spectrum produced by butterfly_stage, which arrives in bit-reversed lane order, and re-emits it as a serial natural-order stream of one complex bin per cycle. It sits between the FFT datapath and downstream consumers such as the magnitude calculator and the packetiser. A two-bank ping-pong buffer lets a new frame be accepted while the previous frame drains.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_pingpong_bank.sv | 62 ++++++
 rtl/fft_output_reorder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the FFT output path.
// Holds the frame geometry, complex word layout and lane index helpers.
package fft_pkg;

    localparam int DATA_W   = 50;
    localparam int N_POINTS = 8;
    localparam int IDX_W    = $clog2(N_POINTS);
    localparam int HALF_W   = DATA_W / 2;

    // Complex bin: re in the upper half, im in the lower half.
    typedef struct packed {
        logic signed [HALF_W-1:0] re;
        logic signed [HALF_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_e;

    function automatic logic [IDX_W-1:0] bitrev3(
        input logic [IDX_W-1:0] idx
    );
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// fft_pingpong_bank: two frame banks with one full flag each.
// Ports: clk_i/rst_i; wr_en_i/wr_bank_i/wr_data_i write a whole frame;
// clr_en_i/clr_bank_i free a bank; rd_bank_i/rd_idx_i -> rd_data_o;
// full_o reports both bank flags.
module fft_pingpong_bank
    import fft_pkg::*;
#(
    parameter int DATA_W   = 50,
    parameter int N_POINTS = 8,
    parameter int IDX_W    = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic              wr_bank_i,
    input  logic [DATA_W-1:0] wr_data_i [N_POINTS-1:0],
    input  logic              clr_en_i,
    input  logic              clr_bank_i,
    input  logic              rd_bank_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [1:0]        full_o
);

    logic [DATA_W-1:0] mem_q [1:0][N_POINTS-1:0];
    logic [DATA_W-1:0] mem_d [1:0][N_POINTS-1:0];
    logic [1:0]        full_q;
    logic [1:0]        full_d;

    // Clear is applied before write; the two never target the
    // same bank because a full bank is never written.
    always_comb begin
        mem_d  = mem_q;
        full_d = full_q;
        if (clr_en_i) begin
            full_d[clr_bank_i] = 1'b0;
        end
        if (wr_en_i) begin
            for (int j = 0; j < N_POINTS; j++) begin
                mem_d[wr_bank_i][j] = wr_data_i[j];
            end
            full_d[wr_bank_i] = 1'b1;
        end
    end

    // Frame data needs no reset: the full flags gate every read.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    assign rd_data_o = mem_q[rd_bank_i][rd_idx_i];
    assign full_o    = full_q;

endmodule

// File: rtl/fft_output_reorder.sv
// fft_output_reorder: ping-pong frame buffer that turns the 8-lane
// bit-reversed spectrum into a serial natural-order bin stream.
// Ports: clk_i, rst_i (sync, active-high);
// frame_i/frame_valid_i/frame_ready_o: parallel frame input;
// sample_o/sample_idx_o/sample_last_o/sample_valid_o/sample_ready_i:
// serial output; overflow_o: sticky dropped-frame flag.
module fft_output_reorder
    import fft_pkg::*;
#(
    parameter int DATA_W      = 50,
    parameter int N_POINTS    = 8,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] frame_i [N_POINTS-1:0],
    input  logic              frame_valid_i,
    output logic              frame_ready_o,
    output logic [DATA_W-1:0] sample_o,
    output logic [IDX_W-1:0]  sample_idx_o,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic              sample_last_o,
    output logic              overflow_o
);

    rd_state_e         state_q;
    rd_state_e         state_d;
    logic              wr_bank_q;
    logic              wr_bank_d;
    logic              rd_bank_q;
    logic              rd_bank_d;
    logic [IDX_W-1:0]  rd_cnt_q;
    logic [IDX_W-1:0]  rd_cnt_d;
    logic [DATA_W-1:0] sample_q;
    logic [DATA_W-1:0] sample_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic              last_q;
    logic              last_d;
    logic              valid_q;
    logic              valid_d;
    logic              ovf_q;
    logic              ovf_d;

    logic [1:0]        full;
    logic [DATA_W-1:0] rd_data;
    logic              frame_ready;
    logic              wr_en;
    logic              clr_en;
    logic              load;
    logic              have_data;
    logic              at_last;
    logic [IDX_W-1:0]  rd_idx_nat;
    logic [IDX_W-1:0]  rd_idx;

    fft_pingpong_bank #(
        .DATA_W   (DATA_W),
        .N_POINTS (N_POINTS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (wr_en),
        .wr_bank_i  (wr_bank_q),
        .wr_data_i  (frame_i),
        .clr_en_i   (clr_en),
        .clr_bank_i (rd_bank_q),
        .rd_bank_i  (rd_bank_q),
        .rd_idx_i   (rd_idx),
        .rd_data_o  (rd_data),
        .full_o     (full)
    );

    assign frame_ready = !full[wr_bank_q];
    assign wr_en       = frame_valid_i && frame_ready;
    assign load        = !valid_q || sample_ready_i;

    // Leaving IDLE on a full bank loads bin 0 in the same cycle,
    // so back-to-back frames stream without a bubble.
    assign have_data  = (state_q == ST_STREAM) || full[rd_bank_q];
    assign rd_idx_nat = (state_q == ST_IDLE) ? '0 : rd_cnt_q;
    assign rd_idx     = BIT_REVERSE ? bitrev3(rd_idx_nat) : rd_idx_nat;
    assign at_last    = (rd_idx_nat == IDX_W'(N_POINTS - 1));

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        sample_d  = sample_q;
        idx_d     = idx_q;
        last_d    = last_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        clr_en    = 1'b0;

        if (wr_en) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (frame_valid_i && !frame_ready) begin
            ovf_d = 1'b1;
        end

        unique case (1'b1)
            (have_data && load): begin
                sample_d = rd_data;
                idx_d    = rd_idx_nat;
                last_d   = at_last;
                valid_d  = 1'b1;
                rd_cnt_d = rd_idx_nat + IDX_W'(1);
                state_d  = ST_STREAM;
                if (at_last) begin
                    clr_en    = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    state_d   = ST_IDLE;
                end
            end
            (have_data && !load): begin
                state_d  = ST_STREAM;
                rd_cnt_d = rd_idx_nat;
            end
            (!have_data && load): begin
                valid_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            sample_q  <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            sample_q  <= sample_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign frame_ready_o  = frame_ready;
    assign sample_o       = sample_q;
    assign sample_idx_o   = idx_q;
    assign sample_last_o  = last_q;
    assign sample_valid_o = valid_q;
    assign overflow_o     = ovf_q;

endmodule
